mux4_scan_sequencer: RTL and testbench
======================================

MUX4_SCAN_SEQUENCER -- requirements
Module: mux4_scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL, default 2, giving the cycles each select code is held before its sample (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: scan request, sampled in IDLE only.
REQ-005 The block SHALL have port cont, input, 1 bit: continuous mode, sampled at end of each scan.
REQ-006 The block SHALL have port abort, input, 1 bit: cancels the scan in progress.
REQ-007 The block SHALL have port y_in, input, 1 bit: output of the downstream 4:1 mux.
REQ-008 The block SHALL have port s0, output, 1 bit: mux select, MSB of the channel index.
REQ-009 The block SHALL have port s1, output, 1 bit: mux select, LSB of the channel index.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-012 The block SHALL have port word, output, 4 bits: captured word; bit0 = a, bit1 = b, bit2 = c, bit3 = d.

Function
REQ-013 Channel index ch[1:0] SHALL map to selects as {s0,s1} = ch: a = 00, b = 01, c = 10, d = 11 (s0=0,s1=1 selects b; s0=1,s1=0 selects c).
REQ-014 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-015 IDLE, start=1 at an edge: the block SHALL enter SCAN with ch=0 and dwell counter cnt=DWELL-1, and busy=1 from that edge.
REQ-016 SCAN with cnt≠0: cnt SHALL decrement; ch and selects SHALL hold.
REQ-017 SCAN with cnt=0: y_in SHALL be captured into shadow bit ch. If ch<3, ch SHALL increment and cnt SHALL reload to DWELL-1.
REQ-018 SCAN with cnt=0 and ch=3: word SHALL load the three shadow bits plus y_in as bit3, and done SHALL be 1 for the following cycle.
REQ-019 In that same end-of-scan cycle (REQ-018), if cont=1 the block SHALL restart SCAN at ch=0, cnt=DWELL-1 with busy held at 1; otherwise it SHALL go to IDLE with busy=0.
REQ-020 Latency: done SHALL rise exactly 4*DWELL edges after the edge that accepted start; y_in SHALL be sampled DWELL cycles after each select change.
REQ-021 start while busy SHALL be ignored; start held high in IDLE SHALL begin a new scan on the cycle after return to IDLE.
REQ-022 abort=1 in SCAN SHALL force IDLE at that edge, with ch=0, busy=0, no done, and word unchanged; abort SHALL take priority over sampling and over end-of-scan.
REQ-023 abort in IDLE SHALL have no effect and SHALL block start in the same cycle.
REQ-024 word SHALL change only at end of a completed scan; partial scans SHALL never be visible on word.
REQ-025 In IDLE, s0/s1 SHALL drive 00 (channel a).

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, set state=IDLE, ch=0, cnt=0, s0=0, s1=0, busy=0, done=0, word=0000, shadow=0000.
REQ-027 Reset mid-scan SHALL discard the scan; after release the block SHALL wait for a fresh start.
REQ-028 The first scan SHALL be accepted on the first edge after rst_n is seen high with start=1.

Verification
REQ-029 The bench SHALL run a single scan: DWELL=2, mux inputs a=1, b=0, c=1, d=1, one-cycle start. Required: selects 00,01,10,11 each held 2 cycles; done at edge 8; word=1101; busy falls with done.
REQ-030 The bench SHALL run a continuous scan: cont=1, a..d=0,1,1,0. Required: done every 8 cycles, word=0110 each time, busy never drops.
REQ-031 The bench SHALL test abort: abort at cycle 5 of a scan. Required: busy=0 next edge, no done, word retains previous value, selects=00.
REQ-032 The bench SHALL test ignored start: start pulsed at cycle 3 of a scan. Required: no effect; exactly one done at edge 8.
REQ-033 The bench SHALL test asynchronous reset: rst_n low mid-cycle during a scan. Required: all outputs zero before the next edge; no done after release until start.
REQ-034 The bench SHALL test DWELL=1: a=0, b=1, c=0, d=0. Required: selects change every cycle; done at edge 4; word=0010.

Source files
------------

// File: rtl/mux4_scan_sequencer.sv
// mux4_scan_sequencer: walks a downstream 4:1 mux through channels a..d,
// dwelling DWELL cycles per channel, and assembles the sampled bits into a word.
`default_nettype none

module mux4_scan_sequencer #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic       y_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] word
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] RELOAD = 4'(DWELL - 1);

  state_t     state, state_nxt;
  logic [1:0] ch, ch_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] shadow, shadow_nxt;
  logic [3:0] word_nxt;
  logic       done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= 2'd0;
      cnt    <= 4'd0;
      shadow <= 3'd0;
      word   <= 4'd0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ch     <= ch_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      word   <= word_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    word_nxt   = word;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SCAN;
          ch_nxt    = 2'd0;
          cnt_nxt   = RELOAD;
        end
      end
      SCAN: begin
        // abort outranks both the per-channel sample and the end-of-scan load
        if (abort) begin
          state_nxt = IDLE;
          ch_nxt    = 2'd0;
          cnt_nxt   = 4'd0;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (ch != 2'd3) begin
          shadow_nxt[ch] = y_in;
          ch_nxt         = ch + 2'd1;
          cnt_nxt        = RELOAD;
        end else begin
          word_nxt  = {y_in, shadow};
          done_nxt  = 1'b1;
          ch_nxt    = 2'd0;
          state_nxt = cont ? SCAN : IDLE;
          cnt_nxt   = cont ? RELOAD : 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s0   = ch[1];
  assign s1   = ch[0];
  assign busy = (state == SCAN);

endmodule

`default_nettype wire

// File: tb/tb_mux4_scan_sequencer.sv
// Self-checking bench for mux4_scan_sequencer: DWELL=2 and DWELL=1 instances
// driven against a per-cycle model of the expected select/done/word sequence.
`default_nettype none

module tb_mux4_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [2];
  logic       cont_v  [2];
  logic       abort_v [2];
  logic       y_v     [2];
  logic       s0_v    [2];
  logic       s1_v    [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic [3:0] word_v  [2];
  logic [3:0] pat_v   [2];
  logic [3:0] exp_word[2];
  int         dwell_of[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The 4:1 mux the sequencer is steering; pattern bit0=a .. bit3=d.
  assign y_v[0] = pat_v[0][{s0_v[0], s1_v[0]}];
  assign y_v[1] = pat_v[1][{s0_v[1], s1_v[1]}];

  mux4_scan_sequencer #(.DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cont(cont_v[0]),
    .abort(abort_v[0]), .y_in(y_v[0]), .s0(s0_v[0]), .s1(s1_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .word(word_v[0])
  );

  mux4_scan_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cont(cont_v[1]),
    .abort(abort_v[1]), .y_in(y_v[1]), .s0(s0_v[1]), .s1(s1_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .word(word_v[1])
  );

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({s0_v[d], s1_v[d], busy_v[d], done_v[d], word_v[d]} !== 8'h00) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got=%0h exp=0", d,
                 {s0_v[d], s1_v[d], busy_v[d], done_v[d], word_v[d]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs nscans back-to-back scans (cont high until the last one); optionally
  // pulses start at cycle glitch of the first scan, which must be ignored.
  task automatic run_scan(input int d, input logic [3:0] pat, input int nscans,
                          input int glitch);
    int dw = dwell_of[d];
    pat_v[d]   = pat;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int s = 0; s < nscans; s++) begin
      for (int k = 0; k < 4 * dw; k++) begin
        cont_v[d]  = (s < nscans - 1);
        start_v[d] = (s == 0 && k == glitch);
        checks++;
        if ({s0_v[d], s1_v[d]} !== 2'(k / dw) || busy_v[d] !== 1'b1) begin
          failures++;
          $display("FAIL scan_sel_busy dut%0d scan%0d cyc%0d got sel=%b busy=%b exp sel=%0d busy=1",
                   d, s, k, {s0_v[d], s1_v[d]}, busy_v[d], k / dw);
        end
        checks++;
        if (done_v[d] !== (s > 0 && k == 0)) begin
          failures++;
          $display("FAIL scan_done dut%0d scan%0d cyc%0d got=%b exp=%b",
                   d, s, k, done_v[d], (s > 0 && k == 0));
        end
        if (s > 0 && k == 0) begin
          checks++;
          if (word_v[d] !== pat) begin
            failures++;
            $display("FAIL cont_word dut%0d scan%0d got=%b exp=%b", d, s, word_v[d], pat);
          end
        end
        @(negedge clk);
      end
    end
    start_v[d]  = 1'b0;
    cont_v[d]   = 1'b0;
    exp_word[d] = pat;
    checks++;
    if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || word_v[d] !== pat) begin
      failures++;
      $display("FAIL scan_end dut%0d got done=%b busy=%b word=%b exp done=1 busy=0 word=%b",
               d, done_v[d], busy_v[d], word_v[d], pat);
    end
    @(negedge clk);
    checks++;
    if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || {s0_v[d], s1_v[d]} !== 2'b00) begin
      failures++;
      $display("FAIL after_end dut%0d got done=%b busy=%b sel=%b exp 0 0 00",
               d, done_v[d], busy_v[d], {s0_v[d], s1_v[d]});
    end
  endtask

  task automatic test_abort();
    pat_v[0] = ~exp_word[0];
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || {s0_v[0], s1_v[0]} !== 2'b00
        || word_v[0] !== exp_word[0]) begin
      failures++;
      $display("FAIL abort_state got busy=%b done=%b sel=%b word=%b exp 0 0 00 %b",
               busy_v[0], done_v[0], {s0_v[0], s1_v[0]}, word_v[0], exp_word[0]);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (done_v[0] !== 1'b0 || word_v[0] !== exp_word[0]) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d got done=%b word=%b exp 0 %b",
                 k, done_v[0], word_v[0], exp_word[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_idle_abort();
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort_blocks_start got busy=%b exp 0", busy_v[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int d = i % 2;
      run_scan(d, 4'($urandom_range(0, 15)), 1 + int'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_async_reset();
    pat_v[0] = 4'b1010;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s0_v[0], s1_v[0], busy_v[0], done_v[0], word_v[0]} !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got=%0h exp=0", {s0_v[0], s1_v[0], busy_v[0], done_v[0], word_v[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || word_v[0] !== 4'd0) begin
        failures++;
        $display("FAIL post_reset_idle cyc%0d got busy=%b done=%b word=%b exp 0 0 0000",
                 k, busy_v[0], done_v[0], word_v[0]);
      end
    end
  endtask

  initial begin
    dwell_of[0] = 2;
    dwell_of[1] = 1;
    for (int d = 0; d < 2; d++) begin
      start_v[d]  = 1'b0;
      cont_v[d]   = 1'b0;
      abort_v[d]  = 1'b0;
      pat_v[d]    = 4'd0;
      exp_word[d] = 4'd0;
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    run_scan(0, 4'b1101, 1, -1);    // a=1 b=0 c=1 d=1
    run_scan(0, 4'b0111, 1, 3);     // start pulsed mid-scan
    run_scan(0, 4'b0110, 3, -1);    // continuous, a..d = 0,1,1,0
    test_abort();
    test_idle_abort();
    run_scan(1, 4'b0010, 1, -1);    // DWELL=1, a=0 b=1 c=0 d=0
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
